// File: rtl/hpi_bus_engine.sv
// Timed nCS/nRD/nWR bus-cycle engine for the CY7C67300 HPI, plus HPI INT synchroniser.
// One word request becomes SETUP/STROBE/HOLD/RECOVER phases counted in sys_clk cycles.
module hpi_bus_engine #(
  parameter int T_SETUP   = 2,
  parameter int T_STROBE  = 6,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 4
) (
  input  logic        sys_clk,
  input  logic        usbreset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        hpi_csn,
  output logic        hpi_oen,
  output logic        hpi_wen,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_o,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_i,
  input  logic        hpi_irq,
  output logic        irq_sync,
  output logic        irq_rise
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        lat_we;
  logic        start, cur_we, cyc_n;
  logic        csn_n, oen_n, wen_n, oe_n, ack_n, cap;
  logic [1:0]  addr_n;
  logic [15:0] data_o_n;
  logic        irq_s1;

  assign start  = (state == IDLE) && req;
  assign cur_we = start ? we : lat_we;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:
        if (req) begin state_n = SETUP; cnt_n = 8'(T_SETUP - 1); end
      SETUP:
        if (cnt == 8'd0) begin state_n = STROBE; cnt_n = 8'(T_STROBE - 1); end
        else cnt_n = cnt - 8'd1;
      STROBE:
        if (cnt == 8'd0) begin state_n = HOLD; cnt_n = 8'(T_HOLD - 1); end
        else cnt_n = cnt - 8'd1;
      HOLD:
        if (cnt == 8'd0) begin state_n = RECOVER; cnt_n = 8'(T_RECOVER - 1); end
        else cnt_n = cnt - 8'd1;
      RECOVER:
        if (cnt == 8'd0) begin state_n = IDLE; cnt_n = 8'd0; end
        else cnt_n = cnt - 8'd1;
      default: begin state_n = IDLE; cnt_n = 8'd0; end
    endcase
  end

  // Outputs are registered from the next state so pins change exactly on phase boundaries.
  always_comb begin
    cyc_n    = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
    csn_n    = ~cyc_n;
    oen_n    = ~((state_n == STROBE) && !cur_we);
    wen_n    = ~((state_n == STROBE) && cur_we);
    oe_n     = cyc_n && cur_we;
    addr_n   = start ? addr : hpi_addr;
    data_o_n = (start && we) ? wdata : hpi_data_o;
    ack_n    = (state == HOLD) && (cnt == 8'd0);
    cap      = (state == STROBE) && (cnt == 8'd0) && !lat_we;
  end

  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      lat_we      <= 1'b0;
      hpi_csn     <= 1'b1;
      hpi_oen     <= 1'b1;
      hpi_wen     <= 1'b1;
      hpi_addr    <= 2'd0;
      hpi_data_o  <= 16'd0;
      hpi_data_oe <= 1'b0;
      ack         <= 1'b0;
      rdata       <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lat_we      <= cur_we;
      hpi_csn     <= csn_n;
      hpi_oen     <= oen_n;
      hpi_wen     <= wen_n;
      hpi_addr    <= addr_n;
      hpi_data_o  <= data_o_n;
      hpi_data_oe <= oe_n;
      ack         <= ack_n;
      busy        <= (state_n != IDLE);
      if (cap) rdata <= hpi_data_i;
    end
  end

  // irq_rise is computed one stage early so it lines up with irq_sync & ~irq_sync_d.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      irq_s1   <= 1'b0;
      irq_sync <= 1'b0;
      irq_rise <= 1'b0;
    end else begin
      irq_s1   <= hpi_irq;
      irq_sync <= irq_s1;
      irq_rise <= irq_s1 & ~irq_sync;
    end
  end

endmodule

// File: tb/tb_hpi_bus_engine.sv
// Directed bench for hpi_bus_engine: cycle-accurate pin windows, read capture, reset abort,
// request dropping, back-to-back throughput and the INT synchroniser.
module tb_hpi_bus_engine;

  logic        sys_clk = 1'b0;
  logic        usbreset;
  logic        req, we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        ack, busy;
  logic [15:0] rdata;
  logic        hpi_csn, hpi_oen, hpi_wen, hpi_data_oe;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_o, hpi_data_i, rd_val;
  logic        hpi_irq, irq_sync, irq_rise;

  int checks = 0;
  int fails  = 0;

  always #5 sys_clk = ~sys_clk;

  // Device model: drives the read value only while nRD is low.
  assign hpi_data_i = hpi_oen ? 16'hDEAD : rd_val;

  hpi_bus_engine dut (
    .sys_clk(sys_clk), .usbreset(usbreset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .hpi_csn(hpi_csn),
    .hpi_oen(hpi_oen), .hpi_wen(hpi_wen), .hpi_addr(hpi_addr),
    .hpi_data_o(hpi_data_o), .hpi_data_oe(hpi_data_oe), .hpi_data_i(hpi_data_i),
    .hpi_irq(hpi_irq), .irq_sync(irq_sync), .irq_rise(irq_rise)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {csn,oen,wen,oe,ack,busy} in cycle n after a request sampled at edge 0.
  function automatic logic [5:0] exp_ctl(input int n, input logic w);
    logic cyc, stb;
    cyc = (n >= 1) && (n <= 10);
    stb = (n >= 3) && (n <= 8);
    return {~cyc, ~(stb && !w), ~(stb && w), cyc && w, n == 11, (n >= 1) && (n <= 14)};
  endfunction

  function automatic logic [5:0] ctl();
    return {hpi_csn, hpi_oen, hpi_wen, hpi_data_oe, ack, busy};
  endfunction

  task automatic issue(input logic w, input logic [1:0] a, input logic [15:0] d);
    @(negedge sys_clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge sys_clk);
    #1 req = 1'b0;
  endtask

  initial begin
    int acks, ack_at[$], run, min_run, rises;
    logic seen_low;
    usbreset = 1'b1; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 16'd0;
    rd_val = 16'h0000; hpi_irq = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_ctl", 32'(ctl()), 32'(6'b111000));
    check("reset_addr_data", {14'd0, hpi_addr, hpi_data_o}, 32'd0);
    check("reset_rdata_irq", {rdata, 14'd0, irq_sync, irq_rise}, 32'd0);
    usbreset = 1'b0;
    @(negedge sys_clk);
    check("idle_ctl", 32'(ctl()), 32'(6'b111000));

    // Write A5C3 to address 2
    issue(1'b1, 2'd2, 16'hA5C3);
    for (int n = 1; n <= 16; n++) begin
      @(negedge sys_clk);
      check($sformatf("wr_ctl_c%0d", n), 32'(ctl()), 32'(exp_ctl(n, 1'b1)));
      if (n >= 1 && n <= 10) check($sformatf("wr_data_c%0d", n), 32'(hpi_data_o), 32'hA5C3);
      if (n == 5 || n == 12) check($sformatf("wr_addr_c%0d", n), 32'(hpi_addr), 32'd2);
    end

    // Read from address 1, device returns 1234
    rd_val = 16'h1234;
    issue(1'b0, 2'd1, 16'hFFFF);
    for (int n = 1; n <= 16; n++) begin
      @(negedge sys_clk);
      check($sformatf("rd_ctl_c%0d", n), 32'(ctl()), 32'(exp_ctl(n, 1'b0)));
      if (n == 8)  check("rd_before_capture", 32'(rdata), 32'h0);
      if (n == 11) check("rd_at_ack", 32'(rdata), 32'h1234);
      if (n == 5)  check("rd_addr", 32'(hpi_addr), 32'd1);
    end
    rd_val = 16'hBEEF;
    issue(1'b1, 2'd0, 16'h0F0F);
    repeat (16) @(negedge sys_clk);
    check("rd_hold_after_write", 32'(rdata), 32'h1234);

    // Reset in the middle of a write strobe
    issue(1'b1, 2'd3, 16'h5555);
    repeat (5) @(negedge sys_clk);
    check("pre_reset_strobe", 32'(ctl()), 32'(exp_ctl(5, 1'b1)));
    #2 usbreset = 1'b1;
    #1 check("async_reset_ctl", 32'(ctl()), 32'(6'b111000));
    @(negedge sys_clk);
    usbreset = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (ack) acks++;
    end
    check("reset_no_ack", acks, 0);
    check("reset_idle_busy", 32'(busy), 32'd0);

    // Second request during busy is dropped
    issue(1'b0, 2'd1, 16'h0);
    acks = 0;
    ack_at.delete();
    for (int n = 1; n <= 30; n++) begin
      @(negedge sys_clk);
      if (ack) begin acks++; ack_at.push_back(n); end
      if (n == 5) req = 1'b1;
      if (n == 6) req = 1'b0;
    end
    check("drop_ack_count", acks, 1);
    check("drop_ack_cycle", (ack_at.size() > 0) ? ack_at[0] : -1, 11);

    // req held high for 40 edges -> three cycles
    @(negedge sys_clk);
    req = 1'b1; we = 1'b1; addr = 2'd3; wdata = 16'h00FF;
    @(posedge sys_clk);
    acks = 0; ack_at.delete(); run = 0; min_run = 1000; seen_low = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge sys_clk);
      if (n == 40) req = 1'b0;
      if (ack) begin acks++; ack_at.push_back(n); end
      if (hpi_csn) run++;
      else begin
        if (seen_low && run > 0 && run < min_run) min_run = run;
        seen_low = 1'b1;
        run = 0;
      end
    end
    check("b2b_ack_count", acks, 3);
    check("b2b_ack0", (ack_at.size() > 0) ? ack_at[0] : -1, 11);
    check("b2b_ack1", (ack_at.size() > 1) ? ack_at[1] : -1, 26);
    check("b2b_ack2", (ack_at.size() > 2) ? ack_at[2] : -1, 41);
    check("b2b_csn_gap", min_run, 5);

    // IRQ held high for 20 cycles
    @(negedge sys_clk);
    hpi_irq = 1'b1;
    rises = 0;
    @(negedge sys_clk);
    check("irq_sync_lag1", 32'(irq_sync), 32'd0);
    if (irq_rise) rises++;
    @(negedge sys_clk);
    check("irq_sync_lag2", {30'd0, irq_sync, irq_rise}, 32'd3);
    if (irq_rise) rises++;
    repeat (18) begin
      @(negedge sys_clk);
      if (irq_rise) rises++;
    end
    hpi_irq = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      if (irq_rise) rises++;
    end
    check("irq_level_one_pulse", rises, 1);
    check("irq_sync_fall", 32'(irq_sync), 32'd0);

    // One-cycle glitch
    hpi_irq = 1'b1;
    @(negedge sys_clk);
    hpi_irq = 1'b0;
    rises = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (irq_rise) rises++;
    end
    check("irq_glitch_at_most_one", 32'(rises <= 1), 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
